uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: BAUD_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 Parameter: DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_data  input  8  byte to transmit.
REQ-006 Port: in_valid  input  1  in_data offered this cycle.
REQ-007 Port: in_ready  output  1  FIFO can accept; equals not-full.
REQ-008 Port: ovf_clr  input  1  clears sticky overflow flag.
REQ-009 Port: uart_tx  output  1  serial line, idle high, registered.
REQ-010 Port: tx_busy  output  1  high while a frame is on the line.
REQ-011 Port: tx_done  output  1  one-cycle pulse at end of each frame.
REQ-012 Port: fifo_count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-013 Port: ovf  output  1  sticky flag, write attempted while full.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; no parity.
REQ-015 Every bit, including start and stop, SHALL be held on uart_tx for exactly BAUD_DIV cycles; a frame spans exactly 10*BAUD_DIV cycles.
REQ-016 Push: the byte SHALL be written when in_valid && in_ready at a rising edge; fifo_count increments at that edge.
REQ-017 in_ready SHALL be derived from the registered count; a pop in the same cycle does not make a full FIFO accept.
REQ-018 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_count unchanged and preserve order.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; output order is strictly FIFO.
REQ-020 in_valid && !in_ready SHALL drop the byte and set ovf at that edge; ovf stays set until ovf_clr; if set and clear coincide, set wins.
REQ-021 FSM states: IDLE, START, DATA, STOP; a down-counter loaded with BAUD_DIV-1 times each bit; a 3-bit index selects the data bit.
REQ-022 IDLE: uart_tx=1; if fifo_count != 0, pop the head into the shift register and go to START, with uart_tx=0 from that edge.
REQ-023 START -> DATA after BAUD_DIV cycles; DATA -> STOP after 8th bit's BAUD_DIV cycles; STOP -> IDLE, or directly to START if FIFO non-empty (no idle gap between back-to-back frames).
REQ-024 Latency: a byte pushed into an empty FIFO with FSM in IDLE at edge k SHALL drive the start bit from edge k+1.
REQ-025 tx_busy SHALL be high exactly when the state is not IDLE, except during back-to-back STOP->START where it stays high continuously.
REQ-026 tx_done SHALL pulse high for exactly one cycle, registered at the edge ending each stop bit.
REQ-027 Bytes pushed during an active frame SHALL not disturb the frame in flight.

Reset
REQ-028 While rst_n=0 at an edge: state=IDLE, uart_tx=1, tx_busy=0, tx_done=0, fifo_count=0, ovf=0, pointers=0, in_ready=1 after that edge.
REQ-029 Reset mid-frame SHALL abort the frame: uart_tx returns high at the reset edge and all queued bytes are discarded.

Verification
REQ-030 Push 0x55 into idle block, BAUD_DIV=4 -> uart_tx low from next edge, then 1,0,1,0,1,0,1,0, stop 1, each 4 cycles; tx_done pulses once at cycle 40.
REQ-031 Push 0x41,0x42,0x43 back-to-back -> three frames, 30*BAUD_DIV cycles, no idle gap, tx_busy continuously high, three tx_done pulses.
REQ-032 Fill DEPTH=16 while line busy, then push 0xFF -> in_ready=0, fifo_count=16, ovf=1, 0xFF never transmitted; pulse ovf_clr -> ovf=0.
REQ-033 Push and pop in same cycle at fifo_count=5 -> fifo_count stays 5, byte order unchanged on the line.
REQ-034 Assert rst_n=0 during data bit 3 of 0xA5 with 4 bytes queued -> uart_tx=1, fifo_count=0, tx_busy=0 after the edge; no further frames.
REQ-035 Checker SHALL sample the line at bit midpoints and flag any frame whose stop bit is 0 or whose bit duration is not BAUD_DIV.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// Each bit is held for BAUD_DIV cycles. A non-empty queue starts its next frame straight out of the stop bit.
module uart_tx_fifo #(
  parameter int BAUD_DIV = 868,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ovf_clr,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push, pop, bit_end, done_n;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full slot.
  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_cnt == '0);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE:  if (fifo_count != '0) begin
               pop     = 1'b1;
               state_n = START;
             end
      START: if (bit_end) state_n = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (bit_end) begin
               done_n = 1'b1;
               if (fifo_count != '0) begin
                 pop     = 1'b1;
                 state_n = START;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A dropped write beats a clear in the same cycle.
      if (in_valid && !in_ready) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state   <= state_n;
      tx_done <= done_n;
      tx_busy <= (state_n != IDLE);
      if (pop) begin
        shreg    <= mem[rd_ptr];
        baud_cnt <= BAUD_LAST;
        uart_tx  <= 1'b0;
      end else begin
        case (state)
          START: if (bit_end) begin
                   baud_cnt <= BAUD_LAST;
                   bit_idx  <= 3'd0;
                   uart_tx  <= shreg[0];
                 end else begin
                   baud_cnt <= baud_cnt - BW'(1);
                 end
          DATA:  if (bit_end) begin
                   baud_cnt <= BAUD_LAST;
                   bit_idx  <= bit_idx + 3'd1;
                   uart_tx  <= (bit_idx == 3'd7) ? 1'b1 : shreg[bit_idx + 3'd1];
                 end else begin
                   baud_cnt <= baud_cnt - BW'(1);
                 end
          STOP:  if (bit_end) uart_tx <= 1'b1;
                 else         baud_cnt <= baud_cnt - BW'(1);
          default: uart_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A queue-based frame-timing reference model and a midpoint line decoder run every cycle.
// Directed table vectors and hand-written corner sequences run first, then random traffic.
module tb_uart_tx_fifo;
  localparam int BD    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0, ovf_clr = 1'b0;
  logic          in_ready, uart_tx, tx_busy, tx_done, ovf;
  logic [CW-1:0] fifo_count;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD_DIV(BD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ovf_clr(ovf_clr), .uart_tx(uart_tx),
    .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count), .ovf(ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Inputs as seen at each rising edge
  logic       s_rst = 1'b0, s_valid = 1'b0, s_clr = 1'b0, s_seen = 1'b0;
  logic [7:0] s_data = 8'h00;
  always @(posedge clk) begin
    s_rst   <= rst_n;
    s_valid <= in_valid;
    s_data  <= in_data;
    s_clr   <= ovf_clr;
    s_seen  <= 1'b1;
  end

  // Reference model: queue of pending bytes plus cycles left in the current frame.
  logic [7:0] mq[$];
  logic [7:0] expq[$];
  int         m_t = 0;
  int         m_sz;
  logic       m_rdy, m_pop;
  logic       m_ovf = 1'b0, m_done = 1'b0;
  logic [7:0] m_cur = 8'h00;

  function automatic logic exp_line();
    int idx;
    if (m_t == 0) return 1'b1;
    idx = (10*BD - m_t) / BD;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  logic       dec_on = 1'b0, dec_prev = 1'b1;
  int         dec_cnt = 0, dec_bit, ff_seen = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    if (s_seen) begin
      if (!s_rst) begin
        mq.delete();
        expq.delete();
        m_t = 0;
        m_ovf = 1'b0;
        m_done = 1'b0;
      end else begin
        m_sz   = mq.size();
        m_rdy  = (m_sz < DEPTH);
        m_pop  = (m_t <= 1) && (m_sz > 0);
        m_done = (m_t == 1);
        if (m_t > 0) m_t--;
        if (m_pop) begin
          m_cur = mq.pop_front();
          expq.push_back(m_cur);
          m_t = 10*BD;
        end
        if (s_valid && m_rdy) mq.push_back(s_data);
        if (s_valid && !m_rdy) m_ovf = 1'b1;
        else if (s_clr)        m_ovf = 1'b0;
      end
      chk("uart_tx", uart_tx, exp_line());
      chk("tx_busy", tx_busy, m_t > 0);
      chk("tx_done", tx_done, m_done);
      chk("fifo_count", fifo_count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("ovf", ovf, m_ovf);

      // Line decoder: sample at bit midpoints after each falling start edge
      if (!s_rst) dec_on = 1'b0;
      else if (!dec_on && dec_prev && !uart_tx) begin
        dec_on = 1'b1;
        dec_cnt = 0;
      end
      if (dec_on) begin
        if (dec_cnt % BD == BD/2) begin
          dec_bit = dec_cnt / BD;
          if (dec_bit == 0) chk("dec_start", uart_tx, 0);
          else if (dec_bit <= 8) dec_byte[dec_bit-1] = uart_tx;
          else begin
            chk("dec_stop", uart_tx, 1);
            if (expq.size() == 0) fail("dec_unexpected_frame");
            else chk("dec_byte", dec_byte, expq.pop_front());
            if (dec_byte == 8'hFF) ff_seen++;
            dec_on = 1'b0;
          end
        end
        dec_cnt++;
      end
      dec_prev = uart_tx;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mq.size() == 0 && m_t == 0) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) fail("idle_timeout");
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = line level during bit slot i
  } vec_t;
  vec_t vt[5];

  logic [7:0] rs[5];
  int   dn, ff0, n;
  logic acc;

  initial begin
    vt[0] = '{8'h55, 10'b1010101010};
    vt[1] = '{8'hA5, 10'b1101001010};
    vt[2] = '{8'h00, 10'b1000000000};
    vt[3] = '{8'hFF, 10'b1111111110};
    vt[4] = '{8'h01, 10'b1000000010};
    rs    = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) tick();
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single frames from a table
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      in_data = vt[v].data;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      dn = 0;
      for (int c = 1; c <= 10*BD + 1; c++) begin
        tick();
        if ((c-1) % BD == BD/2 && (c-1)/BD < 10)
          chk("vec_bit", uart_tx, vt[v].line[(c-1)/BD]);
        if (c == 10*BD + 1) chk("vec_done_edge", tx_done, 1);
        if (tx_done) dn++;
      end
      chk("vec_done_count", dn, 1);
    end

    // Back-to-back frames: busy never drops, three done pulses
    wait_idle();
    acc = 1'b1;
    dn = 0;
    for (int j = 0; j <= 30*BD + 2; j++) begin
      in_valid = (j < 3);
      in_data = 8'h41 + 8'(j);
      tick();
      if (j >= 1 && j <= 30*BD) acc = acc & tx_busy;
      if (tx_done) dn++;
    end
    in_valid = 1'b0;
    chk("b2b_busy", acc, 1);
    chk("b2b_done", dn, 3);

    // Overflow while the line is busy
    wait_idle();
    for (int c = 0; c < 17; c++) begin
      in_valid = 1'b1;
      in_data = 8'h10 + 8'(c);
      tick();
    end
    chk("full_ready", in_ready, 0);
    chk("full_count", fifo_count, 16);
    in_data = 8'hFF;
    tick();
    chk("ovf_set", ovf, 1);
    chk("ovf_count", fifo_count, 16);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", ovf, 1);
    in_valid = 1'b0;
    tick();
    chk("ovf_clr", ovf, 0);
    ovf_clr = 1'b0;
    ff0 = ff_seen;
    wait_idle();
    chk("ff_dropped", ff_seen - ff0, 0);

    // Push and pop on the same edge at count 5
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data = 8'h60 + 8'(c);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (m_t != 1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail("pp_timeout");
    chk("pp_before", fifo_count, 5);
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("pp_after", fifo_count, 5);
    wait_idle();

    // Reset during data bit 3 of 0xA5 with four bytes queued
    for (int c = 0; c <= 2 + 4*BD; c++) begin
      in_valid = (c < 5);
      if (c < 5) in_data = rs[c];
      if (c == 2 + 4*BD) rst_n = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_rst_line", uart_tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    rst_n = 1'b1;
    acc = 1'b1;
    dn = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      acc = acc & uart_tx & !tx_busy;
      if (tx_done) dn++;
    end
    chk("post_rst_quiet", acc, 1);
    chk("post_rst_done", dn, 0);

    // Random traffic, alternating sparse and bursty phases
    for (int i = 0; i < 4000; i++) begin
      if (((i / 400) % 2) == 1) in_valid = ($urandom_range(0, 1) == 1);
      else                      in_valid = ($urandom_range(0, 29) == 0);
      in_data = 8'($urandom_range(0, 255));
      ovf_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    wait_idle();
    repeat (4) tick();
    chk("exp_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
